// File: rtl/parcel_aligner.sv
// Instruction aligner between the fetch buffer and decode.
// Fetch entries of IFB_PARCELS 16-bit parcels are queued in a circular buffer
// of BUF_PARCELS slots. One RVC or RVI instruction is extracted per cycle from
// the head of the queue.
module parcel_aligner #(
  parameter int IFB_PARCELS = 2,
  parameter int BUF_PARCELS = 4,
  localparam int OFF_W = (IFB_PARCELS > 1) ? $clog2(IFB_PARCELS) : 1,
  localparam int LVL_W = $clog2(BUF_PARCELS + 1)
) (
  input  logic                     s_clk_i,
  input  logic                     s_resetn_i,
  input  logic                     s_flush_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  input  logic [16*IFB_PARCELS-1:0] s_instr_i,
  input  logic [OFF_W-1:0]         s_offset_i,
  input  logic [2:0]               s_ferr_i,
  input  logic [IFB_PARCELS-1:0]   s_pred_i,
  input  logic                     s_stall_i,
  output logic                     s_valid_o,
  output logic [31:0]              s_instr_o,
  output logic                     s_rvc_o,
  output logic [2:0]               s_ferr_o,
  output logic                     s_pred_o,
  output logic                     s_aerr_o,
  output logic [LVL_W-1:0]         s_level_o
);

  localparam int PTR_W = (BUF_PARCELS > 1) ? $clog2(BUF_PARCELS) : 1;
  localparam logic [2:0] FETCH_VALID = 3'b000;
`ifdef PROT_INTF
  localparam logic [2:0] FETCH_INCER = 3'b111;
`endif

  // queue storage: one slot = {parcel, ferr, pred}
  logic [15:0]            parcel_q [BUF_PARCELS];
  logic [2:0]             ferr_q   [BUF_PARCELS];
  logic [BUF_PARCELS-1:0] pred_q;

  logic [PTR_W-1:0] rd, wr, rd1;
  logic [LVL_W-1:0] count;

  // push side
  logic [15:0]            in_parcel [IFB_PARCELS];
  logic [15:0]            wdata     [IFB_PARCELS];
  logic [PTR_W-1:0]       slot      [IFB_PARCELS];
  logic [IFB_PARCELS-1:0] wen;
  logic [IFB_PARCELS-1:0] wpred;
  int                     push_n;
  logic                   push;

  // pop side
  logic emit_one, emit_two, pop;
  int   pop_n;

  // modulo add for an arbitrary (non power-of-two) depth; a < BUF_PARCELS
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int a);
    int v;
    v = int'(p) + a;
    if (v >= BUF_PARCELS) v = v - BUF_PARCELS;
    return PTR_W'(v);
  endfunction

  assign s_ready_o = (BUF_PARCELS - int'(count)) >= IFB_PARCELS;
  assign s_level_o = count;
  assign rd1       = wrap_add(rd, 1);

  // push window: offset up to the first predicted parcel, then slot/data per parcel
  always_comb begin
    int last;
    int src;
    logic found;
    last  = IFB_PARCELS - 1;
    found = 1'b0;
    for (int k = 0; k < IFB_PARCELS; k++) begin
      in_parcel[k] = s_instr_i[16*k +: 16];
      if (!found && k >= int'(s_offset_i) && s_pred_i[k]) begin
        last  = k;
        found = 1'b1;
      end
    end
    if (int'(s_offset_i) < IFB_PARCELS) push_n = last - int'(s_offset_i) + 1;
    else                                push_n = 0;
    push = s_valid_i && s_ready_o && !s_flush_i && (push_n != 0);
    for (int k = 0; k < IFB_PARCELS; k++) begin
      src      = int'(s_offset_i) + k;
      wen[k]   = push && (k < push_n);
      slot[k]  = wrap_add(wr, k);
      wdata[k] = 16'h0;
      wpred[k] = 1'b0;
      if (src < IFB_PARCELS) begin
        wdata[k] = in_parcel[OFF_W'(src)];
        wpred[k] = s_pred_i[OFF_W'(src)];
      end
    end
  end

  // head decode and aligned instruction output
  always_comb begin
    logic head_rvc, head_err, sec_err;
    head_rvc  = parcel_q[rd][1:0] != 2'b11;
    head_err  = ferr_q[rd] != FETCH_VALID;
    sec_err   = ferr_q[rd1] != FETCH_VALID;
`ifdef PROT_INTF
    sec_err   = sec_err && (ferr_q[rd1] != FETCH_INCER);
`endif
    // a faulting head is always emitted alone so decode never waits on its other half
    emit_one  = (count >= LVL_W'(1)) && (head_rvc || head_err);
    emit_two  = (count >= LVL_W'(2)) && !head_rvc && !head_err;
    s_valid_o = 1'b0;
    s_instr_o = 32'h0;
    s_rvc_o   = 1'b0;
    s_ferr_o  = 3'b000;
    s_pred_o  = 1'b0;
    s_aerr_o  = 1'b0;
    pop_n     = 1;
    if (!s_flush_i && emit_one) begin
      s_valid_o = 1'b1;
      s_instr_o = {16'h0, parcel_q[rd]};
      s_rvc_o   = 1'b1;
      s_ferr_o  = ferr_q[rd];
      s_pred_o  = pred_q[rd];
    end else if (!s_flush_i && emit_two) begin
      s_valid_o = 1'b1;
      s_instr_o = {parcel_q[rd1], parcel_q[rd]};
      s_ferr_o  = sec_err ? ferr_q[rd1] : ferr_q[rd];
      s_pred_o  = pred_q[rd1];
      s_aerr_o  = pred_q[rd];
      pop_n     = 2;
    end
    pop = s_valid_o && !s_stall_i;
  end

  // parcel storage writes
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      for (int i = 0; i < BUF_PARCELS; i++) begin
        parcel_q[i] <= 16'h0;
        ferr_q[i]   <= 3'b000;
      end
      pred_q <= '0;
    end else begin
      for (int k = 0; k < IFB_PARCELS; k++) begin
        if (wen[k]) begin
          parcel_q[slot[k]] <= wdata[k];
          ferr_q[slot[k]]   <= s_ferr_i;
          pred_q[slot[k]]   <= wpred[k];
        end
      end
    end
  end

  // pointers and occupancy
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (s_flush_i) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wrap_add(wr, push_n);
      if (pop)  rd <= wrap_add(rd, pop_n);
      count <= LVL_W'(int'(count) + (push ? push_n : 0) - (pop ? pop_n : 0));
    end
  end

endmodule

// File: tb/tb_parcel_aligner.sv
// Directed bench for parcel_aligner (IFB_PARCELS=2, BUF_PARCELS=4).
// Expected instructions are queued when the entry completing them is driven
// and compared when decode consumes them (s_valid_o & ~s_stall_i).
module tb_parcel_aligner;

  logic        clk = 1'b0;
  logic        s_resetn_i;
  logic        s_flush_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [31:0] s_instr_i;
  logic [0:0]  s_offset_i;
  logic [2:0]  s_ferr_i;
  logic [1:0]  s_pred_i;
  logic        s_stall_i;
  logic        s_valid_o;
  logic [31:0] s_instr_o;
  logic        s_rvc_o;
  logic [2:0]  s_ferr_o;
  logic        s_pred_o;
  logic        s_aerr_o;
  logic [2:0]  s_level_o;

  typedef struct packed {
    logic [31:0] instr;
    logic        rvc;
    logic [2:0]  ferr;
    logic        pred;
    logic        aerr;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;

  parcel_aligner #(.IFB_PARCELS(2), .BUF_PARCELS(4)) dut (
    .s_clk_i   (clk),
    .s_resetn_i(s_resetn_i),
    .s_flush_i (s_flush_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .s_instr_i (s_instr_i),
    .s_offset_i(s_offset_i),
    .s_ferr_i  (s_ferr_i),
    .s_pred_i  (s_pred_i),
    .s_stall_i (s_stall_i),
    .s_valid_o (s_valid_o),
    .s_instr_o (s_instr_o),
    .s_rvc_o   (s_rvc_o),
    .s_ferr_o  (s_ferr_o),
    .s_pred_o  (s_pred_o),
    .s_aerr_o  (s_aerr_o),
    .s_level_o (s_level_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [31:0] instr, input logic rvc, input logic [2:0] ferr,
                            input logic pred, input logic aerr);
    exp_t x;
    x.instr = instr; x.rvc = rvc; x.ferr = ferr; x.pred = pred; x.aerr = aerr;
    sb.push_back(x);
  endtask

  task automatic drive(input logic [31:0] instr, input logic off, input logic [2:0] ferr,
                       input logic [1:0] pred);
    s_valid_i  = 1'b1;
    s_instr_i  = instr;
    s_offset_i = off;
    s_ferr_i   = ferr;
    s_pred_i   = pred;
    tick();
    s_valid_i  = 1'b0;
    s_instr_i  = 32'h0;
    s_offset_i = 1'b0;
    s_ferr_i   = 3'b000;
    s_pred_i   = 2'b00;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  // consumer-side scoreboard compare
  always @(negedge clk) begin
    if (s_resetn_i && s_valid_o && !s_stall_i) begin
      if (sb.size() == 0) check("spurious_valid", 64'(s_valid_o), 64'd0);
      else begin
        e = sb.pop_front();
        check("out_instr", 64'(s_instr_o), 64'(e.instr));
        check("out_rvc",   64'(s_rvc_o),   64'(e.rvc));
        check("out_ferr",  64'(s_ferr_o),  64'(e.ferr));
        check("out_pred",  64'(s_pred_o),  64'(e.pred));
        check("out_aerr",  64'(s_aerr_o),  64'(e.aerr));
      end
    end
  end

  initial begin
    s_resetn_i = 1'b0;
    s_flush_i  = 1'b0;
    s_valid_i  = 1'b0;
    s_instr_i  = 32'h0;
    s_offset_i = 1'b0;
    s_ferr_i   = 3'b000;
    s_pred_i   = 2'b00;
    s_stall_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(s_valid_o), 64'd0);
    check("rst_instr", 64'(s_instr_o), 64'd0);
    check("rst_rvc",   64'(s_rvc_o),   64'd0);
    check("rst_ferr",  64'(s_ferr_o),  64'd0);
    check("rst_pred",  64'(s_pred_o),  64'd0);
    check("rst_aerr",  64'(s_aerr_o),  64'd0);
    check("rst_level", 64'(s_level_o), 64'd0);
    check("rst_ready", 64'(s_ready_o), 64'd1);
    s_resetn_i = 1'b1;
    tick();

    // two RVC parcels in one entry
    expect_out(32'h0000_4501, 1'b1, 3'b000, 1'b0, 1'b0);
    expect_out(32'h0000_0001, 1'b1, 3'b000, 1'b0, 1'b0);
    drive(32'h0001_4501, 1'b0, 3'b000, 2'b00);
    check("rvc_level2", 64'(s_level_o), 64'd2);
    tick();
    check("rvc_level1", 64'(s_level_o), 64'd1);
    tick();
    check("rvc_level0", 64'(s_level_o), 64'd0);
    drain("rvc_drain");

    // back-to-back RVI entries, second one wraps the queue
    expect_out(32'h1111_0093, 1'b0, 3'b000, 1'b0, 1'b0);
    expect_out(32'h0001_2223, 1'b0, 3'b000, 1'b0, 1'b0);
    drive(32'h1111_0093, 1'b0, 3'b000, 2'b00);
    drive(32'h0001_2223, 1'b0, 3'b000, 2'b00);
    drain("rvi_drain");

    // RVI split across entries, first entry starts at offset 1
    drive(32'h0513_ffff, 1'b1, 3'b000, 2'b00);
    check("split_level1", 64'(s_level_o), 64'd1);
    tick();
    tick();
    check("split_novalid", 64'(s_valid_o), 64'd0);
    check("split_hold", 64'(s_level_o), 64'd1);
    expect_out(32'h0000_0513, 1'b0, 3'b000, 1'b0, 1'b0);
    expect_out(32'h0000_0001, 1'b1, 3'b000, 1'b0, 1'b0);
    drive(32'h0001_0000, 1'b0, 3'b000, 2'b00);
    drain("split_drain");

    // predicted parcel 0 drops parcel 1
    expect_out(32'h0000_a001, 1'b1, 3'b000, 1'b1, 1'b0);
    drive(32'h0001_a001, 1'b0, 3'b000, 2'b01);
    check("pred_level1", 64'(s_level_o), 64'd1);
    tick();
    check("pred_level0", 64'(s_level_o), 64'd0);
    drain("pred_drain");

    // prediction on the first half of an RVI
    drive(32'h1234_0093, 1'b0, 3'b000, 2'b01);
    check("aerr_level1", 64'(s_level_o), 64'd1);
    expect_out(32'h5678_0093, 1'b0, 3'b000, 1'b0, 1'b1);
    expect_out(32'h0000_0001, 1'b1, 3'b000, 1'b0, 1'b0);
    drive(32'h0001_5678, 1'b0, 3'b000, 2'b00);
    drain("aerr_drain");

    // faulting single parcel emitted alone
    expect_out(32'h0000_0093, 1'b1, 3'b001, 1'b0, 1'b0);
    drive(32'h0093_ffff, 1'b1, 3'b001, 2'b00);
    drain("ferr_drain");
    tick();
    check("ferr_level0", 64'(s_level_o), 64'd0);

    // stall fills the queue, then flush empties it
    s_stall_i = 1'b1;
    drive(32'h0001_4501, 1'b0, 3'b000, 2'b01);
    check("stall_level1", 64'(s_level_o), 64'd1);
    check("stall_ready1", 64'(s_ready_o), 64'd1);
    drive(32'h0001_4501, 1'b0, 3'b000, 2'b00);
    check("full_level3", 64'(s_level_o), 64'd3);
    check("full_ready0", 64'(s_ready_o), 64'd0);
    drive(32'h2222_0001, 1'b0, 3'b000, 2'b00);
    check("full_nopush", 64'(s_level_o), 64'd3);
    check("stall_valid", 64'(s_valid_o), 64'd1);
    check("stall_head", 64'(s_instr_o), 64'h4501);
    tick();
    tick();
    s_flush_i  = 1'b1;
    s_valid_i  = 1'b1;
    s_instr_i  = 32'h0001_0001;
    #1;
    check("flush_valid", 64'(s_valid_o), 64'd0);
    @(posedge clk);
    #1;
    s_flush_i = 1'b0;
    s_valid_i = 1'b0;
    s_instr_i = 32'h0;
    check("flush_level0", 64'(s_level_o), 64'd0);
    check("flush_valid0", 64'(s_valid_o), 64'd0);
    check("flush_ready", 64'(s_ready_o), 64'd1);
    s_stall_i = 1'b0;
    tick();
    check("flush_stays0", 64'(s_level_o), 64'd0);

    // asynchronous reset in the middle of operation
    s_stall_i = 1'b1;
    drive(32'h0001_4501, 1'b0, 3'b000, 2'b00);
    check("arst_pre", 64'(s_level_o), 64'd2);
    #2;
    s_resetn_i = 1'b0;
    #1;
    check("arst_level", 64'(s_level_o), 64'd0);
    check("arst_valid", 64'(s_valid_o), 64'd0);
    check("arst_ready", 64'(s_ready_o), 64'd1);
    sb.delete();
    @(posedge clk);
    #1;
    s_resetn_i = 1'b1;
    s_stall_i  = 1'b0;
    expect_out(32'h0000_4501, 1'b1, 3'b000, 1'b0, 1'b0);
    expect_out(32'h0000_0001, 1'b1, 3'b000, 1'b0, 1'b0);
    drive(32'h0001_4501, 1'b0, 3'b000, 2'b00);
    check("arst_first_push", 64'(s_level_o), 64'd2);
    drain("arst_drain");
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
